// File: rtl/dcm_sup_pkg.sv
// Shared state encodings and default timing constants for the DCM lock supervisor.
package dcm_sup_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        RESET     = 3'd1,
        SETTLE    = 3'd2,
        READY     = 3'd3,
        FAULT     = 3'd4
    } dcm_state_t;

    localparam int TIMER_W = 16;

    localparam int DEF_TICK_DIV      = 2;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_RESET_CYCLES  = 10;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 15;

endpackage

// File: rtl/dcm_channel_fsm.sv
// One supervised DCM: lock synchronizer, lock/reset/settle FSM and its counters.
// Optional retry limit with FAULT state is enabled by DCM_RETRY_LIMIT_EN.
module dcm_channel_fsm
    import dcm_sup_pkg::*;
#(
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic locked_async,
    output logic dcm_reset,
    output logic channel_ready,
    output logic lost_lock,
    output logic fault
);

    logic               sync_q;
    logic               lk;
    dcm_state_t         state, state_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic [TIMER_W-1:0] stable_cnt, stable_next;
    logic               lost_next;
`ifdef DCM_RETRY_LIMIT_EN
    logic [3:0]         retry_cnt, retry_next;
`endif

    always_comb begin
        state_next  = state;
        timer_next  = timer;
        stable_next = stable_cnt;
        lost_next   = 1'b0;
`ifdef DCM_RETRY_LIMIT_EN
        retry_next  = retry_cnt;
`endif
        case (state)
            WAIT_LOCK: begin
                // A lock seen on the timeout tick still wins over the reset pulse
                if (lk) begin
                    state_next  = SETTLE;
                    stable_next = '0;
                end else if (tick) begin
                    if (timer == TIMER_W'(LOCK_TIMEOUT - 1)) begin
                        timer_next = '0;
`ifdef DCM_RETRY_LIMIT_EN
                        state_next = (retry_cnt == 4'(MAX_RETRIES)) ? FAULT : RESET;
`else
                        state_next = RESET;
`endif
                    end else begin
                        timer_next = timer + 1'b1;
                    end
                end
            end
            RESET: begin
                if (tick) begin
                    if (timer == TIMER_W'(RESET_CYCLES - 1)) begin
                        state_next = WAIT_LOCK;
                        timer_next = '0;
`ifdef DCM_RETRY_LIMIT_EN
                        if (retry_cnt != 4'hF) retry_next = retry_cnt + 4'd1;
`endif
                    end else begin
                        timer_next = timer + 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (!lk) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                end else if (tick) begin
                    stable_next = stable_cnt + 1'b1;
                    if (stable_cnt == TIMER_W'(STABLE_CYCLES - 1)) state_next = READY;
                end
            end
            READY: begin
`ifdef DCM_RETRY_LIMIT_EN
                retry_next = '0;
`endif
                if (!lk) begin
                    state_next = WAIT_LOCK;
                    timer_next = '0;
                    lost_next  = 1'b1;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = WAIT_LOCK;
            end
        endcase
    end

    // Outputs are registered decodes of the next state so they move with the state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q        <= 1'b0;
            lk            <= 1'b0;
            state         <= WAIT_LOCK;
            timer         <= '0;
            stable_cnt    <= '0;
            dcm_reset     <= 1'b0;
            channel_ready <= 1'b0;
            lost_lock     <= 1'b0;
`ifdef DCM_RETRY_LIMIT_EN
            retry_cnt     <= '0;
            fault         <= 1'b0;
`endif
        end else begin
            sync_q        <= locked_async;
            lk            <= sync_q;
            state         <= state_next;
            timer         <= timer_next;
            stable_cnt    <= stable_next;
            dcm_reset     <= (state_next == RESET);
            channel_ready <= (state_next == READY);
            lost_lock     <= lost_next;
`ifdef DCM_RETRY_LIMIT_EN
            retry_cnt     <= retry_next;
            fault         <= (state_next == FAULT);
`endif
        end
    end

`ifndef DCM_RETRY_LIMIT_EN
    assign fault = 1'b0;
`endif

endmodule

// File: rtl/dcm_lock_supervisor.sv
// Supervises all DCM_SP channels: shared tick prescaler, per-channel FSMs, global ready.
// Define DCM_RETRY_LIMIT_EN to latch a per-channel fault after MAX_RETRIES reset pulses.
module dcm_lock_supervisor
    import dcm_sup_pkg::*;
#(
    parameter int NUM_DCM       = 2,
    parameter int TICK_DIV      = DEF_TICK_DIV,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
    input  logic               input_clk,
    input  logic               reset_n,
    input  logic [NUM_DCM-1:0] dcm_locked,
    output logic [NUM_DCM-1:0] dcm_reset,
    output logic [NUM_DCM-1:0] channel_ready,
    output logic               all_ready,
    output logic [NUM_DCM-1:0] lost_lock,
    output logic [NUM_DCM-1:0] fault
);

    logic [15:0] pre_cnt;
    logic        tick;

    assign tick = (pre_cnt == 16'(TICK_DIV - 1));

    always_ff @(posedge input_clk) begin
        if (!reset_n) begin
            pre_cnt   <= '0;
            all_ready <= 1'b0;
        end else begin
            pre_cnt   <= tick ? 16'd0 : pre_cnt + 16'd1;
            all_ready <= &channel_ready;
        end
    end

    for (genvar i = 0; i < NUM_DCM; i++) begin : g_chan
        dcm_channel_fsm #(
            .LOCK_TIMEOUT (LOCK_TIMEOUT),
            .RESET_CYCLES (RESET_CYCLES),
            .STABLE_CYCLES(STABLE_CYCLES),
            .MAX_RETRIES  (MAX_RETRIES)
        ) u_chan (
            .clk          (input_clk),
            .reset_n      (reset_n),
            .tick         (tick),
            .locked_async (dcm_locked[i]),
            .dcm_reset    (dcm_reset[i]),
            .channel_ready(channel_ready[i]),
            .lost_lock    (lost_lock[i]),
            .fault        (fault[i])
        );
    end

endmodule

// File: tb/tb_dcm_lock_supervisor.sv
// Directed bench for dcm_lock_supervisor with short timing constants (TICK_DIV=1).
// With DCM_RETRY_LIMIT_EN defined the timeout run also checks the retry limit.
module tb_dcm_lock_supervisor;

    logic       clk;
    logic       reset_n;
    logic [1:0] locked;
    logic [1:0] dcm_reset;
    logic [1:0] channel_ready;
    logic       all_ready;
    logic [1:0] lost_lock;
    logic [1:0] fault;

    int vectors;
    int miscompares;

    dcm_lock_supervisor #(
        .NUM_DCM      (2),
        .TICK_DIV     (1),
        .LOCK_TIMEOUT (8),
        .RESET_CYCLES (3),
        .STABLE_CYCLES(4),
        .MAX_RETRIES  (2)
    ) dut (
        .input_clk    (clk),
        .reset_n      (reset_n),
        .dcm_locked   (locked),
        .dcm_reset    (dcm_reset),
        .channel_ready(channel_ready),
        .all_ready    (all_ready),
        .lost_lock    (lost_lock),
        .fault        (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic rst_n, input logic [1:0] lock);
        reset_n = rst_n;
        locked  = lock;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic       pulse;
        logic       flt;
        logic [1:0] exp_rdy;

        vectors     = 0;
        miscompares = 0;

        // Reset state
        applyStimulus(1'b0, 2'b11);
        cycles(2);
        checkOutput("rst_dcm_reset", 8'(dcm_reset), 8'h0);
        checkOutput("rst_ready", 8'(channel_ready), 8'h0);
        checkOutput("rst_all_ready", 8'(all_ready), 8'h0);
        checkOutput("rst_lost_lock", 8'(lost_lock), 8'h0);
        checkOutput("rst_fault", 8'(fault), 8'h0);

        // Both locked from release: ready after edge 7, all_ready after edge 8
        applyStimulus(1'b1, 2'b11);
        for (int e = 1; e <= 8; e++) begin
            cycles(1);
            checkOutput($sformatf("lock_ready_e%0d", e), 8'(channel_ready), (e >= 7) ? 8'h3 : 8'h0);
            checkOutput($sformatf("lock_all_e%0d", e), 8'(all_ready), (e >= 8) ? 8'h1 : 8'h0);
            checkOutput($sformatf("lock_rst_e%0d", e), 8'(dcm_reset), 8'h0);
        end

        // Channel 1 drops lock: ready falls 3 edges later with a lost_lock pulse
        applyStimulus(1'b1, 2'b01);
        cycles(2);
        checkOutput("drop_ready_d2", 8'(channel_ready), 8'h3);
        checkOutput("drop_lost_d2", 8'(lost_lock), 8'h0);
        cycles(1);
        checkOutput("drop_ready_d3", 8'(channel_ready), 8'h1);
        checkOutput("drop_lost_d3", 8'(lost_lock), 8'h2);
        checkOutput("drop_all_d3", 8'(all_ready), 8'h1);
        cycles(1);
        checkOutput("drop_lost_d4", 8'(lost_lock), 8'h0);
        checkOutput("drop_all_d4", 8'(all_ready), 8'h0);

        // Channel 0 never locks: 3-cycle reset pulse every 11 cycles after 8 timeout ticks
        applyStimulus(1'b0, 2'b10);
        cycles(1);
        applyStimulus(1'b1, 2'b10);
        for (int e = 1; e <= 40; e++) begin
            cycles(1);
            pulse = (e >= 8) && (((e - 8) % 11) < 3);
            flt   = 1'b0;
`ifdef DCM_RETRY_LIMIT_EN
            pulse = pulse && (((e - 8) / 11) < 2);
            flt   = (e >= 30);
`endif
            exp_rdy = {(e >= 7), 1'b0};
            checkOutput($sformatf("to_rst_e%0d", e), 8'(dcm_reset), 8'({1'b0, pulse}));
            checkOutput($sformatf("to_ready_e%0d", e), 8'(channel_ready), 8'(exp_rdy));
            checkOutput($sformatf("to_fault_e%0d", e), 8'(fault), 8'({1'b0, flt}));
        end

        // Reset in the middle of a pulse cuts it and restarts the timeout from 0
        applyStimulus(1'b0, 2'b10);
        cycles(1);
        applyStimulus(1'b1, 2'b10);
        cycles(9);
        checkOutput("mid_pulse_high", 8'(dcm_reset), 8'h1);
        applyStimulus(1'b0, 2'b10);
        cycles(1);
        checkOutput("mid_pulse_cut", 8'(dcm_reset), 8'h0);
        checkOutput("mid_pulse_ready", 8'(channel_ready), 8'h0);
        applyStimulus(1'b1, 2'b10);
        for (int e = 1; e <= 8; e++) begin
            cycles(1);
            checkOutput($sformatf("restart_rst_e%0d", e), 8'(dcm_reset), (e == 8) ? 8'h1 : 8'h0);
        end

        // Two-cycle lock glitch on channel 0: settle aborts quietly, timer restarts
        applyStimulus(1'b0, 2'b10);
        cycles(1);
        applyStimulus(1'b1, 2'b10);
        for (int e = 1; e <= 16; e++) begin
            cycles(1);
            checkOutput($sformatf("glitch_rst_e%0d", e), 8'(dcm_reset[0]), (e == 16) ? 8'h1 : 8'h0);
            checkOutput($sformatf("glitch_lost_e%0d", e), 8'(lost_lock), 8'h0);
            checkOutput($sformatf("glitch_rdy0_e%0d", e), 8'(channel_ready[0]), 8'h0);
            if (e == 3) applyStimulus(1'b1, 2'b11);
            if (e == 5) applyStimulus(1'b1, 2'b10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
